uart_tx_fifo: RTL

//  Synchronous transmit FIFO directly upstream of the UART transmitter. Accepts bytes written through the
//  APB TX-data register and delivers them one byte per read strobe. The transmitter issues an active-low

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_fifo_ram.sv | 27 ++
 rtl/uart_tx_fifo.sv | 86 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants used by the transmit path.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_TXFIFO_DEPTH  = 16;
    localparam int UART_TXFIFO_AW     = 4;
    localparam int UART_TXFIFO_AFULL  = 12;

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the TX FIFO: one synchronous write port, one asynchronous read port, no reset.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_TXFIFO_DEPTH,
    parameter int ADDR_W = UART_TXFIFO_AW,
    parameter int WIDTH  = UART_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding the UART transmitter; pointers carry an extra wrap bit so
// empty/full/level all fall out of the two pointer registers.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = UART_TXFIFO_DEPTH,
    parameter int ADDR_W    = UART_TXFIFO_AW,
    parameter int WIDTH     = UART_DATA_W,
    parameter int AFULL_LVL = UART_TXFIFO_AFULL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              wen,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rd_n,
    output logic [WIDTH-1:0]  rdata,
    output logic              empty,
    output logic              full,
    output logic              afull,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam logic [ADDR_W:0] AFULL_THR = AFULL_LVL[ADDR_W:0];

    logic [ADDR_W:0]  wPtr;
    logic [ADDR_W:0]  rPtr;
    logic [WIDTH-1:0] ramRdata;
    logic             readAcc;
    logic             writeAcc;
    logic             ovfSet;

    // Status is derived purely from the pointer registers, never from the strobes.
    assign empty = (wPtr == rPtr);
    assign full  = (wPtr[ADDR_W-1:0] == rPtr[ADDR_W-1:0]) && (wPtr[ADDR_W] != rPtr[ADDR_W]);
    assign level = wPtr - rPtr;
    assign afull = (level >= AFULL_THR);

    // A read frees a slot in the same cycle, so a full FIFO can still take a concurrent write.
    assign readAcc  = !flush && !rd_n && !empty;
    assign writeAcc = !flush && wen && (!full || readAcc);
    assign ovfSet   = !flush && wen && full && !readAcc;

    uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (WIDTH)
    ) u_ram (
        .clk    (clk),
        .we     (writeAcc),
        .waddr  (wPtr[ADDR_W-1:0]),
        .wdata  (wdata),
        .raddr  (rPtr[ADDR_W-1:0]),
        .rdata  (ramRdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wPtr     <= '0;
            rPtr     <= '0;
            rdata    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wPtr     <= '0;
            rPtr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (writeAcc) begin
                wPtr <= wPtr + 1'b1;
            end
            if (readAcc) begin
                rPtr  <= rPtr + 1'b1;
                rdata <= ramRdata;
            end
            // A new overflow event wins over a clear arriving in the same cycle.
            if (ovfSet) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
